// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store initiator for the five-stage MIPS pipeline.
// Runs one outstanding request/ack transaction on the data bus per aligned
// M-stage memory access. Stores get lane placement and byte enables. Loads get
// lane extraction and sign extension. Misaligned accesses are flagged and are
// never issued. A request with no ack is abandoned after TIMEOUT REQ cycles.
//
// Ports
//   clk, reset       clock; asynchronous active-low reset
//   M_MemRead/Write  access request from the M-stage instruction
//   M_DM_A, M_DM_WD  byte address and right-aligned store data
//   store_sel        00 word, 01 byte, 10 half, 11 word
//   load_sel         00 word, 01 signed byte, 10 signed half, 11 zero
//   M_stall          freeze F/D/E/M while the access is pending
//   M_DM_out         load result, held until the next load completes
//   M_AdEL/M_AdES    misaligned load/store, only reported in IDLE
//   bus_err          one-cycle pulse in DONE after a timeout
//   bus_*            request/ack data bus

// One byte lane of the store path: the data byte and enable bit for lane LANE.
module m_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] sel,
  input  logic [1:0] a,
  input  logic [7:0] wd_b,   // WD[7:0], replicated for byte stores
  input  logic [7:0] wd_h,   // WD byte that lands here for half stores
  input  logic [7:0] wd_w,   // WD byte that lands here for word stores
  output logic [7:0] wbyte,
  output logic       be
);
  always_comb begin
    wbyte = wd_w;
    be    = 1'b1;
    case (sel)
      2'b01: begin
        wbyte = wd_b;
        be    = (a == 2'(LANE));
      end
      2'b10: begin
        wbyte = wd_h;
        be    = (a[1] == 1'(LANE / 2));
      end
      default: ;
    endcase
  end
endmodule

module m_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic [31:0] M_DM_A,
  input  logic [31:0] M_DM_WD,
  input  logic [1:0]  store_sel,
  input  logic [1:0]  load_sel,
  output logic        M_stall,
  output logic [31:0] M_DM_out,
  output logic        M_AdEL,
  output logic        M_AdES,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] tcnt;
  logic [1:0] a_q, lsel_q;

  // A store wins when both read and write are requested.
  logic       access, misal, start, expire;
  logic [1:0] size_sel;

  assign access   = M_MemRead | M_MemWrite;
  assign size_sel = M_MemWrite ? store_sel : load_sel;

  always_comb begin
    case (size_sel)
      2'b01:   misal = 1'b0;
      2'b10:   misal = M_DM_A[0];
      default: misal = (M_DM_A[1:0] != 2'b00);
    endcase
  end

  assign M_AdEL  = (state == S_IDLE) & M_MemRead & ~M_MemWrite & misal;
  assign M_AdES  = (state == S_IDLE) & M_MemWrite & misal;
  assign start   = (state == S_IDLE) & access & ~misal;
  assign M_stall = start | (state == S_REQ);
  // Last REQ cycle: TIMEOUT REQ cycles without an ack end the transaction.
  assign expire  = (tcnt == 8'(TIMEOUT - 1));

  // Store lanes.
  logic [NUM_LANES-1:0][7:0] wdata_n;
  logic [NUM_LANES-1:0]      be_n;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    m_lsu_lane #(.LANE(i)) u_lane (
      .sel   (store_sel),
      .a     (M_DM_A[1:0]),
      .wd_b  (M_DM_WD[7:0]),
      .wd_h  (M_DM_WD[8*(i%2) +: 8]),
      .wd_w  (M_DM_WD[8*i +: 8]),
      .wbyte (wdata_n[i]),
      .be    (be_n[i])
    );
  end

  // Load extract from the registered lane offset.
  logic [31:0] rsh, ld_ext;
  assign rsh = bus_rdata >> {a_q, 3'b000};

  always_comb begin
    case (lsel_q)
      2'b00:   ld_ext = bus_rdata;
      2'b01:   ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      2'b10:   ld_ext = a_q[1] ? {{16{bus_rdata[31]}}, bus_rdata[31:16]}
                               : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      a_q       <= '0;
      lsel_q    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      M_DM_out  <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state     <= S_REQ;
          tcnt      <= '0;
          bus_req   <= 1'b1;
          bus_we    <= M_MemWrite;
          bus_addr  <= {M_DM_A[31:2], 2'b00};
          bus_wdata <= wdata_n;
          bus_be    <= M_MemWrite ? be_n : 4'b0000;
          lsel_q    <= load_sel;
          a_q       <= M_DM_A[1:0];
        end
        S_REQ: begin
          if (bus_ack) begin
            state   <= S_DONE;
            bus_req <= 1'b0;
            if (!bus_we) M_DM_out <= ld_ext;
          end else if (expire) begin
            // Abandoned: loads return 0, stores are dropped.
            state   <= S_DONE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (!bus_we) M_DM_out <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_lsu.sv
module tb_m_lsu;
  logic        clk = 0, reset = 0;
  logic        M_MemRead = 0, M_MemWrite = 0;
  logic [31:0] M_DM_A = 0, M_DM_WD = 0;
  logic [1:0]  store_sel = 0, load_sel = 0;
  logic        M_stall, M_AdEL, M_AdES, bus_err, bus_req, bus_we;
  logic [31:0] M_DM_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 0;
  logic [31:0] bus_rdata = 0;

  int checks = 0, errors = 0;

  m_lsu #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite),
    .M_DM_A(M_DM_A), .M_DM_WD(M_DM_WD), .store_sel(store_sel), .load_sel(load_sel),
    .M_stall(M_stall), .M_DM_out(M_DM_out), .M_AdEL(M_AdEL), .M_AdES(M_AdES),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] dm;
    logic        err;
  } done_exp_t;

  bus_exp_t  bq[$];
  done_exp_t dq[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: compares bus fields on the first REQ cycle, REQ length and the
  // load result / error flag in the DONE cycle.
  initial begin : monitor
    logic     prev;
    int       len;
    bus_exp_t cur;
    prev = 0;
    len  = 0;
    cur  = '{default: 0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 0;
        len  = 0;
      end else begin
        if (bus_req && !prev) begin
          if (bq.size() == 0) begin
            chk("bus_unexpected_req", 32'd1, 32'd0);
          end else begin
            cur = bq.pop_front();
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_we", 32'(bus_we), 32'(cur.we));
            chk("bus_be", 32'(bus_be), 32'(cur.be));
            if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
          end
          len = 0;
        end
        if (bus_req) begin
          len++;
          chk("bus_addr_stable", bus_addr, cur.addr);
        end
        if (!bus_req && prev) begin
          chk("req_cycles", 32'(len), 32'(cur.len));
          chk("done_stall", 32'(M_stall), 32'd0);
          if (dq.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            done_exp_t d;
            d = dq.pop_front();
            chk("M_DM_out", M_DM_out, d.dm);
            chk("bus_err", 32'(bus_err), 32'(d.err));
          end
        end
        prev = bus_req;
      end
    end
  end

  // One M-stage access. Expected values are supplied by the caller; the
  // responder acks after 'waits' REQ cycles unless noack is set.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] ss, input logic [1:0] ls,
                        input int waits, input logic noack, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_dm, input logic exp_err, input int exp_stall,
                        output logic ae_l, output logic ae_s);
    int stalls, reqs;
    bit done;
    stalls = 0; reqs = 0; done = 0; ae_l = 0; ae_s = 0;
    if (exp_stall != 0) begin
      bq.push_back('{addr: {a[31:2], 2'b00}, wdata: exp_wdata, we: wr, be: exp_be,
                     len: noack ? 255 : waits + 1});
      dq.push_back('{dm: exp_dm, err: exp_err});
    end
    @(posedge clk); #1;
    M_MemRead = rd; M_MemWrite = wr; M_DM_A = a; M_DM_WD = wd;
    store_sel = ss; load_sel = ls;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin ae_l = M_AdEL; ae_s = M_AdES; end
      if (M_stall) stalls++;
      if (bus_req) begin
        reqs++;
        if (!noack && reqs == waits + 1) begin bus_ack = 1; bus_rdata = rdata; end
      end else if (reqs > 0 || !M_stall) begin
        done = 1;
      end
      if (!done) begin @(posedge clk); #1; bus_ack = 0; bus_rdata = 32'h0; end
    end
    chk("access_completed", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
    M_MemRead = 0; M_MemWrite = 0; M_DM_A = 0; M_DM_WD = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    logic el, es;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_dm_out", M_DM_out, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    reset = 1;
    repeat (2) @(negedge clk);

    // word store, zero wait
    access(0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0,
           4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 2, el, es);
    // byte store, lane 3
    access(0, 1, 32'h0000_2003, 32'h0000_00A5, 2'b01, 2'b00, 0, 0, 0,
           4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 2, el, es);
    // signed half load, upper half, 3 wait cycles
    access(1, 0, 32'h0000_3002, 32'h0, 2'b00, 2'b10, 3, 0, 32'h8001_1234,
           4'b0000, 32'h0, 32'hFFFF_8001, 0, 5, el, es);
    // misaligned half store
    access(0, 1, 32'h0000_0005, 32'h1234, 2'b10, 2'b00, 0, 0, 0,
           4'b0, 32'h0, 32'h0, 0, 0, el, es);
    chk("AdES_half", 32'(es), 32'd1);
    chk("AdEL_on_store", 32'(el), 32'd0);
    @(negedge clk);
    chk("misaligned_no_req", 32'(bus_req), 32'd0);
    // misaligned word load
    access(1, 0, 32'h0000_0006, 32'h0, 2'b00, 2'b00, 0, 0, 0,
           4'b0, 32'h0, 32'h0, 0, 0, el, es);
    chk("AdEL_word", 32'(el), 32'd1);
    chk("AdES_on_load", 32'(es), 32'd0);
    // signed byte load, lane 1
    access(1, 0, 32'h0000_4001, 32'h0, 2'b00, 2'b01, 1, 0, 32'h1234_80FF,
           4'b0000, 32'h0, 32'hFFFF_FF80, 0, 3, el, es);
    // read+write together is a store: half store, upper lanes; M_DM_out holds
    access(1, 1, 32'h0000_0012, 32'h0000_BEEF, 2'b10, 2'b00, 0, 0, 0,
           4'b1100, 32'hBEEF_BEEF, 32'hFFFF_FF80, 0, 2, el, es);
    // word load
    access(1, 0, 32'h0000_4000, 32'h0, 2'b00, 2'b00, 0, 0, 32'h1234_5678,
           4'b0000, 32'h0, 32'h1234_5678, 0, 2, el, es);
    // positive half load, lower half
    access(1, 0, 32'h0000_0010, 32'h0, 2'b00, 2'b10, 2, 0, 32'h5555_7FFE,
           4'b0000, 32'h0, 32'h0000_7FFE, 0, 4, el, es);
    // load_sel 11 returns zero
    access(1, 0, 32'h0000_0020, 32'h0, 2'b00, 2'b11, 0, 0, 32'hFFFF_FFFF,
           4'b0000, 32'h0, 32'h0, 0, 2, el, es);
    // word load to make M_DM_out non-zero before the timeout
    access(1, 0, 32'h0000_0040, 32'h0, 2'b00, 2'b00, 1, 0, 32'hA5A5_5A5A,
           4'b0000, 32'h0, 32'hA5A5_5A5A, 0, 3, el, es);
    // timeout: no ack for 255 REQ cycles
    access(1, 0, 32'h0000_0044, 32'h0, 2'b00, 2'b00, 0, 1, 0,
           4'b0000, 32'h0, 32'h0, 1, 256, el, es);
    @(negedge clk);
    chk("bus_err_one_cycle", 32'(bus_err), 32'd0);
    // signed byte load, lane 0
    access(1, 0, 32'h0000_0050, 32'h0, 2'b00, 2'b01, 0, 0, 32'h0000_00C3,
           4'b0000, 32'h0, 32'hFFFF_FFC3, 0, 2, el, es);

    // reset in the 2nd REQ cycle of a load
    bq.push_back('{addr: 32'h0000_9000, wdata: 32'h0, we: 1'b0, be: 4'b0000, len: 0});
    @(posedge clk); #1;
    M_MemRead = 1; M_DM_A = 32'h0000_9000; load_sel = 2'b00;
    repeat (3) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid_bus_we", 32'(bus_we), 32'd0);
    chk("rst_mid_bus_addr", bus_addr, 32'd0);
    chk("rst_mid_bus_wdata", bus_wdata, 32'd0);
    chk("rst_mid_bus_be", 32'(bus_be), 32'd0);
    chk("rst_mid_dm_out", M_DM_out, 32'd0);
    chk("rst_mid_bus_err", 32'(bus_err), 32'd0);
    M_MemRead = 0; M_DM_A = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    // fresh load after release
    access(1, 0, 32'h0000_8000, 32'h0, 2'b00, 2'b00, 0, 0, 32'hCAFE_F00D,
           4'b0000, 32'h0, 32'hCAFE_F00D, 0, 2, el, es);

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_lsu.md
# m_lsu

M-stage load/store initiator for the five-stage MIPS pipeline. It takes the memory-access request of the instruction in M and runs a single-outstanding request/acknowledge transaction on the data bus: byte-lane placement and byte enables for stores, lane extraction and sign extension for loads. It stalls the pipeline while a transaction is in flight. It flags misaligned accesses and bus timeouts instead of issuing them.

## Interface
Parameters:
- TIMEOUT, 255, cycles in REQ without bus_ack before the transaction is abandoned (1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- M_MemRead  in  1  M-stage instruction is a load
- M_MemWrite  in  1  M-stage instruction is a store
- M_DM_A  in  32  byte address
- M_DM_WD  in  32  store data, right-aligned
- store_sel  in  2  00 word, 01 byte, 10 half, 11 treated as word
- load_sel  in  2  00 word, 01 signed byte, 10 signed half, 11 returns 0
- M_stall  out  1  freeze F/D/E/M registers this cycle
- M_DM_out  out  32  load result, valid in DONE and held until the next load completes
- M_AdEL  out  1  misaligned load (combinational)
- M_AdES  out  1  misaligned store (combinational)
- bus_err  out  1  one-cycle pulse in DONE after a timeout
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  {M_DM_A[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables; 0000 on reads
- bus_ack  in  1  responder completes the request on this edge
- bus_rdata  in  32  read word, valid when bus_ack=1

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- Misaligned access:
  - A word access with A[1:0]≠0 is misaligned.
  - A half access with A[0]≠0 is misaligned.
  - Misaligned accesses raise M_AdEL or M_AdES, issue no bus request and cause no stall.
  - Byte accesses are never misaligned.
- Transitions:
  - IDLE→REQ when (M_MemRead|M_MemWrite) is 1 and the access is aligned. On that edge, bus_addr, bus_we, bus_wdata, bus_be, load_sel and A[1:0] are registered.
  - If M_MemRead and M_MemWrite are both 1, the access is a store.
  - REQ→DONE when bus_ack=1 or when the timeout counter reaches TIMEOUT.
  - DONE→IDLE unconditionally.
- Store lanes:
  - Byte: bus_wdata={4{WD[7:0]}}, bus_be=1<<A[1:0].
  - Half: bus_wdata={2{WD[15:0]}}, bus_be=A[1]?1100:0011.
  - Word: bus_wdata=WD, bus_be=1111.
- Load extract: the byte or half selected by the registered A[1:0] from bus_rdata, sign-extended to 32. On the ack edge it is captured into M_DM_out.
- bus_req is a registered output.
  - It is 1 exactly while in REQ.
  - bus_addr, bus_we, bus_wdata and bus_be are stable throughout REQ.
- M_stall is combinational:
  - In IDLE it is 1 when an aligned access is requested.
  - In REQ it is 1.
  - In DONE it is 0.
  - The pipeline therefore advances on the DONE edge and the instruction is not re-issued.
- Timeout:
  - The counter runs 8 bits in REQ and clears on entry to REQ.
  - On expiry the FSM goes to DONE with bus_err=1. M_DM_out is set to 0 for a load. The store is considered dropped.
  - A bus_ack arriving in the same cycle as expiry takes priority (normal completion, bus_err=0).
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, M_DM_out 0, bus_err 0, timeout counter 0.

## Timing
- Zero-wait responder (ack in the first REQ cycle):
  - A load occupies 3 cycles in M: IDLE(stall), REQ(stall), DONE.
  - M_DM_out is valid from the DONE cycle onward.
- An N-wait responder adds N REQ cycles.
- bus_ack is only sampled in REQ. An ack in IDLE or DONE is ignored.
- Reset asserted mid-REQ: bus_req drops asynchronously, the FSM is in IDLE on deassertion and the transaction is lost.
- Reset deassertion is treated as synchronous to clk by the upstream synchroniser.
- AdEL and AdES never assert in REQ or DONE. They reflect the current inputs only in IDLE.

## Test plan
- Word store, A=0x0000_1004, WD=0xDEAD_BEEF, ack immediate:
  - Expected: bus_req high 1 cycle, bus_addr=0x1004, be=1111, wdata=0xDEADBEEF.
  - Expected: M_stall high 2 cycles.
- Byte store, A=0x0000_2003, WD=0x0000_00A5:
  - Expected: be=1000, wdata=0xA5A5A5A5.
- Half load, A=0x0000_3002, rdata=0x8001_1234, ack after 3 wait cycles:
  - Expected: M_DM_out=0xFFFF_8001.
  - Expected: stall high 5 cycles.
- Misaligned half store, A=0x0000_0005:
  - Expected: M_AdES=1, bus_req stays 0, M_stall=0.
- No ack for 255 REQ cycles on a load:
  - Expected: DONE with bus_err=1 pulse, M_DM_out=0, back to IDLE.
- reset driven low in the 2nd REQ cycle:
  - Expected: bus_req 0 immediately, all outputs at reset values.
  - Expected: a fresh aligned load after release completes normally.
